// File: rtl/sum_uart_tx.sv
// Operand capture, add/subtract, then UART (8N1) report of the (WIDTH+1)-bit result, MSB byte first.
// Latency: start sampled at an edge -> busy=1, uart_txd=0 (start bit), result valid from that same edge.
// Backpressure: none; start is dropped while busy or while done is high, never queued.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   data_in           shared operand bus; load_a / load_b capture it into A / B (any state)
//   mode              0 = A+B, 1 = A-B, sampled with an accepted start
//   start             compute + transmit request
//   result            registered result snapshot (WIDTH+1 bits)
//   busy / done       transmission in progress / one-cycle end-of-frame pulse
//   uart_txd          serial line, idles high
module sum_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             mode,
    input  logic             start,
    output logic [WIDTH:0]   result,
    output logic             busy,
    output logic             done,
    output logic             uart_txd
);

    // ceil((WIDTH+1)/8)
    localparam int NBYTES = (WIDTH + 8) / 8;
    localparam int BUFW   = NBYTES * 8;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH:0]    result_q;
    logic [WIDTH:0]    sum_d;
    logic [BUFW-1:0]   ext_d;
    logic [BUFW-1:0]   buf_q;       // bytes still waiting, next one in the top byte
    logic [7:0]        cur_q;       // byte on the line, shifted right as bits go out
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [2:0]        bytes_left_q;
    logic              busy_q;
    logic              done_q;
    logic              txd_q;
    logic              baud_done;

    assign baud_done = (baud_q == BAUD_LAST);

    // Result at WIDTH+1 bits; the padding up to a whole number of bytes is
    // the borrow/sign bit for subtract and zero for add.
    always_comb begin
        if (mode) begin
            sum_d = {1'b0, a_q} - {1'b0, b_q};
        end else begin
            sum_d = {1'b0, a_q} + {1'b0, b_q};
        end
        ext_d          = {BUFW{mode & sum_d[WIDTH]}};
        ext_d[WIDTH:0] = sum_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            buf_q        <= '0;
            cur_q        <= '0;
            baud_q       <= '0;
            bit_q        <= '0;
            bytes_left_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            txd_q        <= 1'b1;
        end else begin
            done_q <= 1'b0;
            if (load_a) a_q <= data_in;
            if (load_b) b_q <= data_in;

            // Free-running bit timer while a frame is on the line; it wraps
            // to zero on each bit boundary, so it is zero again in IDLE.
            if (state_q != IDLE) begin
                baud_q <= baud_done ? '0 : baud_q + BAUD_ONE;
            end

            case (state_q)
                IDLE: begin
                    // done_q high means the previous frame ended this cycle;
                    // a start coinciding with it is dropped.
                    if (start && !done_q) begin
                        result_q     <= sum_d;
                        cur_q        <= ext_d[BUFW-1 -: 8];
                        buf_q        <= ext_d << 8;
                        bytes_left_q <= 3'(NBYTES - 1);
                        baud_q       <= '0;
                        bit_q        <= '0;
                        busy_q       <= 1'b1;
                        txd_q        <= 1'b0;
                        state_q      <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (baud_done) begin
                        txd_q   <= cur_q[0];
                        state_q <= DATA_BITS;
                    end
                end
                DATA_BITS: begin
                    if (baud_done) begin
                        if (bit_q == 3'd7) begin
                            bit_q   <= '0;
                            txd_q   <= 1'b1;
                            state_q <= STOP_BIT;
                        end else begin
                            // cur_q[0] is the bit now on the line, so the next is cur_q[1]
                            bit_q <= bit_q + 3'd1;
                            txd_q <= cur_q[1];
                            cur_q <= cur_q >> 1;
                        end
                    end
                end
                STOP_BIT: begin
                    if (baud_done) begin
                        if (bytes_left_q != 3'd0) begin
                            bytes_left_q <= bytes_left_q - 3'd1;
                            cur_q        <= buf_q[BUFW-1 -: 8];
                            buf_q        <= buf_q << 8;
                            txd_q        <= 1'b0;
                            state_q      <= START_BIT;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result   = result_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign uart_txd = txd_q;

endmodule
